// File: rtl/priority_encoder_arb_if.sv
// Request/grant bundle between a priority_encoder_arb and its requesters/consumer.
// The master drives requests and the ready strobe; the slave (arbiter) returns the grant.
interface priority_encoder_arb_if #(
    parameter int N = 32
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic             rr_mode;
    logic             grant_ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic             busy;

    modport master (
        output req, rr_mode, grant_ready,
        input  grant_valid, grant_idx, grant_onehot, busy
    );

    modport slave (
        input  req, rr_mode, grant_ready,
        output grant_valid, grant_idx, grant_onehot, busy
    );
endinterface

// File: rtl/priority_encoder_arb.sv
// Registered N-input priority encoder/arbiter, fixed or round-robin priority,
// with a valid/ready output register so the consumer can stall a pending grant.
module priority_encoder_arb #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    priority_encoder_arb_if.slave bus
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] lo_all;
    logic [IDX_W-1:0] lo_hi;
    logic [N-1:0]     hi_mask;
    logic [N-1:0]     req_hi;
    logic             load;

    // Bits at or above the round-robin pointer; the wrapped part of the scan
    // is covered by falling back to the lowest set bit overall.
    for (genvar g = 0; g < N; g++) begin : g_mask
        assign hi_mask[g] = (g >= int'(rr_ptr));
    end

    assign req_hi = bus.req & hi_mask;

    always_comb begin
        lo_all = '0;
        lo_hi  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) lo_all = IDX_W'(i);
            if (req_hi[i])  lo_hi  = IDX_W'(i);
        end
        sel = (bus.rr_mode && (|req_hi)) ? lo_hi : lo_all;
    end

    assign load     = !bus.grant_valid || bus.grant_ready;
    assign bus.busy = bus.grant_valid && !bus.grant_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.grant_valid  <= 1'b0;
            bus.grant_idx    <= '0;
            bus.grant_onehot <= '0;
            rr_ptr           <= '0;
        end else if (load) begin
            if (|bus.req) begin
                bus.grant_valid  <= 1'b1;
                bus.grant_idx    <= sel;
                bus.grant_onehot <= {{(N-1){1'b0}}, 1'b1} << sel;
                // Explicit wrap so non-power-of-2 N never reaches an index >= N
                rr_ptr           <= (sel == IDX_W'(N - 1)) ? '0 : sel + IDX_W'(1);
            end else begin
                bus.grant_valid  <= 1'b0;
                bus.grant_idx    <= '0;
                bus.grant_onehot <= '0;
            end
        end
    end
endmodule

// File: tb/tb_priority_encoder_arb.sv
// Bench for priority_encoder_arb at N=32 and N=5 against a scan-based reference model.
module tb_priority_encoder_arb;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    priority_encoder_arb_if #(.N(32)) bus32 ();
    priority_encoder_arb_if #(.N(5))  bus5 ();

    priority_encoder_arb #(.N(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    priority_encoder_arb #(.N(5))  dut5  (.clk(clk), .reset(reset), .bus(bus5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the indices in priority order and take the first requester.
    function automatic int pick(input logic [31:0] r, input int n, input bit mode, input int ptr);
        int start;
        start = mode ? ptr : 0;
        for (int k = 0; k < n; k++) begin
            int j;
            j = (start + k) % n;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    int m32_v, m32_i, m32_p;
    int m5_v, m5_i, m5_p;

    always @(posedge clk) begin
        if (reset) begin
            m32_v <= 0; m32_i <= 0; m32_p <= 0;
        end else if (m32_v == 0 || bus32.grant_ready) begin
            if (bus32.req != 0) begin
                m32_v <= 1;
                m32_i <= pick(bus32.req, 32, bus32.rr_mode, m32_p);
                m32_p <= (pick(bus32.req, 32, bus32.rr_mode, m32_p) + 1) % 32;
            end else begin
                m32_v <= 0; m32_i <= 0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m5_v <= 0; m5_i <= 0; m5_p <= 0;
        end else if (m5_v == 0 || bus5.grant_ready) begin
            if (bus5.req != 0) begin
                m5_v <= 1;
                m5_i <= pick({27'd0, bus5.req}, 5, bus5.rr_mode, m5_p);
                m5_p <= (pick({27'd0, bus5.req}, 5, bus5.rr_mode, m5_p) + 1) % 5;
            end else begin
                m5_v <= 0; m5_i <= 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        bus32.req = '0;
        bus5.req  = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus32.req = '1; bus32.rr_mode = 1'b0; bus32.grant_ready = 1'b1;
        bus5.req  = '1; bus5.rr_mode  = 1'b0; bus5.grant_ready  = 1'b1;
        step();
        step();
        checks++;
        if (bus32.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus32.grant_valid); end
        checks++;
        if (bus32.grant_idx !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus32.grant_idx); end
        checks++;
        if (bus32.grant_onehot !== 32'd0) begin errors++; $display("FAIL reset_onehot: got %h want 0", bus32.grant_onehot); end
        checks++;
        if (dut32.rr_ptr !== 5'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut32.rr_ptr); end
        checks++;
        if (bus5.grant_valid !== 1'b0) begin errors++; $display("FAIL reset5_valid: got %b want 0", bus5.grant_valid); end
        reset = 1'b0;
    endtask

    task automatic test_fixed();
        bus32.rr_mode = 1'b0; bus32.grant_ready = 1'b1;
        bus32.req = 32'h8000_0010;
        step();
        checks++;
        if (bus32.grant_valid !== 1'b1 || bus32.grant_idx !== 5'd4) begin
            errors++; $display("FAIL fixed_idx: got v=%b idx=%0d want v=1 idx=4", bus32.grant_valid, bus32.grant_idx);
        end
        checks++;
        if (bus32.grant_onehot !== 32'h10) begin errors++; $display("FAIL fixed_onehot: got %h want 10", bus32.grant_onehot); end
        bus32.req = '0;
        step();
        checks++;
        if (bus32.grant_valid !== 1'b0 || bus32.grant_idx !== 5'd0 || bus32.grant_onehot !== 32'd0) begin
            errors++; $display("FAIL fixed_idle: got v=%b idx=%0d oh=%h want 0/0/0", bus32.grant_valid, bus32.grant_idx, bus32.grant_onehot);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx[5] = '{0, 4, 31, 0, 4};
        pulse_reset();
        bus32.rr_mode = 1'b1; bus32.grant_ready = 1'b1;
        bus32.req = 32'h8000_0011;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (bus32.grant_valid !== 1'b1 || int'(bus32.grant_idx) != exp_idx[k]) begin
                errors++; $display("FAIL rr_seq[%0d]: got v=%b idx=%0d want idx=%0d", k, bus32.grant_valid, bus32.grant_idx, exp_idx[k]);
            end
        end
    endtask

    task automatic test_stall();
        bus32.grant_ready = 1'b0;
        bus32.req = 32'h2;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus32.grant_idx !== 5'd4 || bus32.busy !== 1'b1 || dut32.rr_ptr !== 5'd5) begin
                errors++; $display("FAIL stall_hold[%0d]: got idx=%0d busy=%b ptr=%0d want 4/1/5", k, bus32.grant_idx, bus32.busy, dut32.rr_ptr);
            end
        end
        bus32.grant_ready = 1'b1;
        step();
        checks++;
        if (bus32.grant_valid !== 1'b1 || bus32.grant_idx !== 5'd1 || bus32.busy !== 1'b0) begin
            errors++; $display("FAIL stall_release: got v=%b idx=%0d busy=%b want 1/1/0", bus32.grant_valid, bus32.grant_idx, bus32.busy);
        end
    endtask

    task automatic test_wrap5();
        int exp_idx[3] = '{0, 4, 0};
        pulse_reset();
        bus5.rr_mode = 1'b1; bus5.grant_ready = 1'b1;
        bus5.req = 5'b10001;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus5.grant_valid !== 1'b1 || int'(bus5.grant_idx) != exp_idx[k] || dut5.rr_ptr > 3'd4) begin
                errors++; $display("FAIL wrap5[%0d]: got idx=%0d ptr=%0d want idx=%0d ptr<=4", k, bus5.grant_idx, dut5.rr_ptr, exp_idx[k]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        bus32.rr_mode = 1'b0; bus32.grant_ready = 1'b1;
        bus32.req = 32'h8;
        step();
        bus32.grant_ready = 1'b0;
        step();
        checks++;
        if (bus32.grant_idx !== 5'd3 || bus32.busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall: got idx=%0d busy=%b want 3/1", bus32.grant_idx, bus32.busy);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus32.grant_valid !== 1'b0 || bus32.grant_onehot !== 32'd0 || dut32.rr_ptr !== 5'd0) begin
            errors++; $display("FAIL reset_mid_stall: got v=%b oh=%h ptr=%0d want 0/0/0", bus32.grant_valid, bus32.grant_onehot, dut32.rr_ptr);
        end
        reset = 1'b0;
        bus32.rr_mode = 1'b1; bus32.grant_ready = 1'b1;
        bus32.req = 32'h8000_0011;
        step();
        checks++;
        if (bus32.grant_valid !== 1'b1 || bus32.grant_idx !== 5'd0) begin
            errors++; $display("FAIL rr_restart: got v=%b idx=%0d want 1/0", bus32.grant_valid, bus32.grant_idx);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int sel;
            logic [31:0] r;
            sel = int'($urandom_range(0, 3));
            r = $urandom;
            if (sel == 0) r = '0;
            else if (sel == 1) r = 32'd1 << $urandom_range(0, 31);
            bus32.req = r;
            bus32.rr_mode = 1'($urandom_range(0, 1));
            bus32.grant_ready = ($urandom_range(0, 3) != 0);
            bus5.req = r[4:0];
            bus5.rr_mode = 1'($urandom_range(0, 1));
            bus5.grant_ready = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (int'(bus32.grant_valid) != m32_v || int'(bus32.grant_idx) != m32_i || int'(dut32.rr_ptr) != m32_p
                || bus32.grant_onehot !== (m32_v != 0 ? 32'd1 << m32_i : 32'd0)
                || bus32.busy !== (m32_v != 0 && !bus32.grant_ready)) begin
                errors++; $display("FAIL rand32[%0d]: got v=%b idx=%0d ptr=%0d oh=%h want v=%0d idx=%0d ptr=%0d",
                                   c, bus32.grant_valid, bus32.grant_idx, dut32.rr_ptr, bus32.grant_onehot, m32_v, m32_i, m32_p);
            end
            checks++;
            if (int'(bus5.grant_valid) != m5_v || int'(bus5.grant_idx) != m5_i || int'(dut5.rr_ptr) != m5_p
                || bus5.grant_onehot !== (m5_v != 0 ? 5'd1 << m5_i : 5'd0)
                || bus5.busy !== (m5_v != 0 && !bus5.grant_ready)) begin
                errors++; $display("FAIL rand5[%0d]: got v=%b idx=%0d ptr=%0d oh=%b want v=%0d idx=%0d ptr=%0d",
                                   c, bus5.grant_valid, bus5.grant_idx, dut5.rr_ptr, bus5.grant_onehot, m5_v, m5_i, m5_p);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus32.req = '0; bus32.rr_mode = 1'b0; bus32.grant_ready = 1'b0;
        bus5.req  = '0; bus5.rr_mode  = 1'b0; bus5.grant_ready  = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_stall();
        test_wrap5();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
